// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU multiply sequencer.
// Holds the ALU opcode encoding, the sequencer state enum and the adder carry helper.
package alu_pkg;

  localparam int DW = 16;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_NOT = 2'b11
  } alu_op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_NEGA  = 3'd1,
    ST_NEGB  = 3'd2,
    ST_RUN   = 3'd3,
    ST_NEGLO = 3'd4,
    ST_NEGHI = 3'd5,
    ST_DONE  = 3'd6
  } mul_state_t;

  // Carry out of a+b, recovered from the operand and sum MSBs only.
  function automatic logic add_carry(input logic [DW-1:0] a,
                                     input logic [DW-1:0] b,
                                     input logic [DW-1:0] sum);
    return (a[DW-1] & b[DW-1]) | ((a[DW-1] | b[DW-1]) & ~sum[DW-1]);
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// 16x16->32 shift-add multiply sequencer that borrows the shared combinational ALU.
// Optional `ALU_MUL_SIGNED_EN adds req_signed and the negate pre/post states.
//
// state    | meaning
// IDLE     | req_ready=1, ALU parked (AND 0,0)
// NEGA     | signed build: conditionally negate multiplicand
// NEGB     | signed build: conditionally negate multiplier
// RUN      | one ALU add per cycle, DW iterations
// NEGLO    | signed build: conditionally negate low half
// NEGHI    | signed build: conditionally negate/invert high half
// DONE     | load result regs, then hold rsp_valid until rsp_ready
module alu_mul_seq #(
  parameter int DW    = 16,
  parameter int CNT_W = $clog2(DW)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [DW-1:0] req_a,
  input  logic [DW-1:0] req_b,
`ifdef ALU_MUL_SIGNED_EN
  input  logic          req_signed,
`endif
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_hi,
  output logic [DW-1:0] rsp_lo,
  output logic          rsp_z,
  output logic          rsp_ovf,
  output logic [DW-1:0] alu_ain,
  output logic [DW-1:0] alu_bin,
  output logic [1:0]    alu_op,
  input  logic [DW-1:0] alu_out
);
  import alu_pkg::*;

  mul_state_t state_q, state_d;
  logic [DW-1:0]    mcand_q, mcand_d;
  logic [DW-1:0]    acc_hi_q, acc_hi_d;
  logic [DW-1:0]    lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]    rsp_hi_q, rsp_hi_d;
  logic [DW-1:0]    rsp_lo_q, rsp_lo_d;
  logic             rsp_z_q, rsp_z_d;
  logic             rsp_ovf_q, rsp_ovf_d;
`ifdef ALU_MUL_SIGNED_EN
  logic             sgn_q, sgn_d;
  logic             neg_q, neg_d;
  logic             lz_q, lz_d;
`endif

  alu_op_t          op_c;
  logic [DW-1:0]    ain_c, bin_c;
  logic [DW-1:0]    sum_c;
  logic             carry_c;
  logic             ovf_c;

`ifdef ALU_MUL_SIGNED_EN
  assign ovf_c = sgn_q ? (acc_hi_q != {DW{lo_q[DW-1]}}) : (acc_hi_q != '0);
`else
  assign ovf_c = (acc_hi_q != '0);
`endif

  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    acc_hi_d    = acc_hi_q;
    lo_d        = lo_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_hi_d    = rsp_hi_q;
    rsp_lo_d    = rsp_lo_q;
    rsp_z_d     = rsp_z_q;
    rsp_ovf_d   = rsp_ovf_q;
`ifdef ALU_MUL_SIGNED_EN
    sgn_d       = sgn_q;
    neg_d       = neg_q;
    lz_d        = lz_q;
`endif
    op_c        = ALU_AND;
    ain_c       = '0;
    bin_c       = '0;
    sum_c       = acc_hi_q;
    carry_c     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          mcand_d  = req_a;
          acc_hi_d = '0;
          lo_d     = req_b;
          cnt_d    = '0;
`ifdef ALU_MUL_SIGNED_EN
          sgn_d    = req_signed;
          neg_d    = 1'b0;
          state_d  = ST_NEGA;
`else
          state_d  = ST_RUN;
`endif
        end
      end
`ifdef ALU_MUL_SIGNED_EN
      ST_NEGA: begin
        op_c  = ALU_SUB;
        bin_c = mcand_q;
        if (sgn_q && mcand_q[DW-1]) begin
          mcand_d = alu_out;
          neg_d   = ~neg_q;
        end
        state_d = ST_NEGB;
      end
      ST_NEGB: begin
        op_c  = ALU_SUB;
        bin_c = lo_q;
        if (sgn_q && lo_q[DW-1]) begin
          lo_d  = alu_out;
          neg_d = ~neg_q;
        end
        state_d = ST_RUN;
      end
`endif
      ST_RUN: begin
        op_c    = ALU_ADD;
        ain_c   = acc_hi_q;
        bin_c   = mcand_q;
        sum_c   = lo_q[0] ? alu_out : acc_hi_q;
        carry_c = lo_q[0] & add_carry(acc_hi_q, mcand_q, sum_c);
        acc_hi_d = {carry_c, sum_c[DW-1:1]};
        lo_d     = {sum_c[0], lo_q[DW-1:1]};
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DW-1)) begin
`ifdef ALU_MUL_SIGNED_EN
          state_d = ST_NEGLO;
`else
          state_d = ST_DONE;
`endif
        end
      end
`ifdef ALU_MUL_SIGNED_EN
      ST_NEGLO: begin
        op_c  = ALU_SUB;
        bin_c = lo_q;
        lz_d  = (lo_q == '0);
        if (neg_q) lo_d = alu_out;
        state_d = ST_NEGHI;
      end
      ST_NEGHI: begin
        // Two's complement of {hi,lo}: hi only takes the +1 when lo was zero.
        op_c  = lz_q ? ALU_SUB : ALU_NOT;
        bin_c = acc_hi_q;
        if (neg_q) acc_hi_d = alu_out;
        state_d = ST_DONE;
      end
`endif
      ST_DONE: begin
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
          rsp_hi_d    = acc_hi_q;
          rsp_lo_d    = lo_q;
          rsp_z_d     = ({acc_hi_q, lo_q} == '0);
          rsp_ovf_d   = ovf_c;
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mcand_q     <= '0;
      acc_hi_q    <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_hi_q    <= '0;
      rsp_lo_q    <= '0;
      rsp_z_q     <= 1'b0;
      rsp_ovf_q   <= 1'b0;
`ifdef ALU_MUL_SIGNED_EN
      sgn_q       <= 1'b0;
      neg_q       <= 1'b0;
      lz_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      acc_hi_q    <= acc_hi_d;
      lo_q        <= lo_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hi_q    <= rsp_hi_d;
      rsp_lo_q    <= rsp_lo_d;
      rsp_z_q     <= rsp_z_d;
      rsp_ovf_q   <= rsp_ovf_d;
`ifdef ALU_MUL_SIGNED_EN
      sgn_q       <= sgn_d;
      neg_q       <= neg_d;
      lz_q        <= lz_d;
`endif
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_hi    = rsp_hi_q;
  assign rsp_lo    = rsp_lo_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign alu_op    = op_c;
  assign alu_ain   = ain_c;
  assign alu_bin   = bin_c;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq with a behavioural model of the shared ALU.
// Define ALU_MUL_SIGNED_EN to also exercise the signed build.
module tb_alu_mul_seq;

`ifdef ALU_MUL_SIGNED_EN
  localparam int LAT = 21;
`else
  localparam int LAT = 17;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic        req_signed = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_hi, rsp_lo;
  logic        rsp_z, rsp_ovf;
  logic [15:0] alu_ain, alu_bin, alu_out;
  logic [1:0]  alu_op;

  alu_mul_seq dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
`ifdef ALU_MUL_SIGNED_EN
    .req_signed(req_signed),
`endif
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .rsp_z(rsp_z), .rsp_ovf(rsp_ovf),
    .alu_ain(alu_ain), .alu_bin(alu_bin), .alu_op(alu_op), .alu_out(alu_out)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_out = '0;
    case (alu_op)
      2'b00: alu_out = alu_ain + alu_bin;
      2'b01: alu_out = alu_ain - alu_bin;
      2'b10: alu_out = alu_ain & alu_bin;
      default: alu_out = ~alu_bin;
    endcase
  end

  typedef struct {
    logic [15:0] hi;
    logic [15:0] lo;
    logic        z;
    logic        ovf;
    int          acc;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sgn;
    logic [15:0] hi;
    logic [15:0] lo;
    logic        z;
    logic        ovf;
    int          hold;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic busy = 1'b0;
  logic seen = 1'b0;
  int   add_cnt = 0;
  int   rdy_viol = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      busy = 1'b0;
      seen = 1'b0;
    end else begin
      if (busy) begin
        if (alu_op == 2'b00) add_cnt++;
        if (req_ready) rdy_viol++;
      end
      if (req_valid && req_ready) begin
        busy = 1'b1;
        add_cnt = 0;
        rdy_viol = 0;
      end
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          if (!seen) begin
            chk("latency", cyc - sb[0].acc, LAT);
            seen = 1'b1;
          end
          chk("product", {rsp_hi, rsp_lo}, {sb[0].hi, sb[0].lo});
          chk("rsp_z", {31'd0, rsp_z}, {31'd0, sb[0].z});
          chk("rsp_ovf", {31'd0, rsp_ovf}, {31'd0, sb[0].ovf});
          if (rsp_ready) begin
            chk("run_add_cycles", add_cnt, 16);
            chk("req_ready_busy", rdy_viol, 0);
            void'(sb.pop_front());
            busy = 1'b0;
            seen = 1'b0;
          end
        end
      end
    end
  end

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    #1;
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_data", {rsp_hi, rsp_lo}, 32'd0);
    chk("rst_flags", {30'd0, rsp_z, rsp_ovf}, 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   n;
    @(posedge clk); #1;
    req_a = v.a;
    req_b = v.b;
    req_signed = v.sgn;
    req_valid = 1'b1;
    if (v.hold > 0) rsp_ready = 1'b0;
    e.hi = v.hi; e.lo = v.lo; e.z = v.z; e.ovf = v.ovf; e.acc = cyc + 1;
    sb.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (v.hold > 0) begin
      n = 0;
      while (!rsp_valid && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      repeat (v.hold) @(posedge clk);
      #1;
      rsp_ready = 1'b1;
    end
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      chk("rsp_timeout", 32'd1, 32'd0);
      pulse_reset();
    end
  endtask

  initial begin
    vec_t v;
    int   n;
    vecs.push_back('{16'h0003, 16'h0005, 1'b0, 16'h0000, 16'h000F, 1'b0, 1'b0, 0});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 16'h0001, 1'b0, 1'b1, 0});
    vecs.push_back('{16'h0000, 16'h1234, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 5});
    vecs.push_back('{16'h8000, 16'h0002, 1'b0, 16'h0001, 16'h0000, 1'b0, 1'b1, 0});
    vecs.push_back('{16'h1234, 16'h0010, 1'b0, 16'h0001, 16'h2340, 1'b0, 1'b1, 0});
    vecs.push_back('{16'h0100, 16'h0040, 1'b0, 16'h0000, 16'h4000, 1'b0, 1'b0, 0});
    vecs.push_back('{16'h1234, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 0});
`ifdef ALU_MUL_SIGNED_EN
    vecs.push_back('{16'hFFFD, 16'h0005, 1'b1, 16'hFFFF, 16'hFFF1, 1'b0, 1'b0, 0});
    vecs.push_back('{16'h8000, 16'h8000, 1'b1, 16'h4000, 16'h0000, 1'b0, 1'b1, 0});
    vecs.push_back('{16'hFF00, 16'h0100, 1'b1, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 0});
    vecs.push_back('{16'h0007, 16'hFFFE, 1'b1, 16'hFFFF, 16'hFFF2, 1'b0, 1'b0, 0});
    vecs.push_back('{16'hFFFD, 16'h0005, 1'b0, 16'h0004, 16'hFFF1, 1'b0, 1'b1, 0});
`endif

    #1;
    chk("init_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("init_req_ready", {31'd0, req_ready}, 32'd1);
    chk("init_rsp_data", {rsp_hi, rsp_lo}, 32'd0);
    chk("init_flags", {30'd0, rsp_z, rsp_ovf}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Abort mid-RUN: no response may ever appear for this request.
    @(posedge clk); #1;
    req_a = 16'h0077; req_b = 16'h0099; req_signed = 1'b0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
`ifdef ALU_MUL_SIGNED_EN
    repeat (9) @(posedge clk);
`else
    repeat (7) @(posedge clk);
`endif
    pulse_reset();
    n = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (rsp_valid) n++;
    end
    chk("no_partial_rsp", n, 0);

    v = '{16'h0002, 16'h0002, 1'b0, 16'h0000, 16'h0004, 1'b0, 1'b0, 0};
    run_vec(v);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
